// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: RAM handshake state and arbiter FSM state.
package memory_arbiter_pkg;

  localparam int unsigned WORD_W = 32;

  // RAM model status as seen by the arbiter
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter FSM state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DSVC = 2'd1,
    ISVC = 2'd2,
    ERR  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bus bundle between datapath/RAM (master side) and the memory arbiter (slave side).
//  Datapath: iREN/iaddr -> ihit/iload, dREN/dWEN/daddr/dstore -> dhit/dload
//  RAM:      ramREN/ramWEN/ramaddr/ramstore -> ramload/ramstate
//  Status:   merr (sticky error)
interface memory_arbiter_if;
  import memory_arbiter_pkg::*;

  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              ihit;
  logic [WORD_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dhit;
  logic [WORD_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  ramstate_t         ramstate;
  logic              merr;

  // Arbiter view
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, merr
  );

  // Datapath + RAM view
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, merr
  );
endinterface

// File: rtl/memory_arbiter.sv
// Memory arbiter: shares one single-port RAM between instruction and data ports,
// data first. Registered RAM strobes, one-cycle registered hits, timeout/RAM error
// trap into a sticky ERR state left only by reset.
// Ports: CLK, nRST (async active-low), bus (memory_arbiter_if.slave).
// Optional MEMCTL_STATS_EN: adds saturating icnt/dcnt/stallcnt outputs.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 32
`ifdef MEMCTL_STATS_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic             CLK,
  input  logic             nRST,
  memory_arbiter_if.slave  bus
`ifdef MEMCTL_STATS_EN
  , output logic [CNT_W-1:0] icnt
  , output logic [CNT_W-1:0] dcnt
  , output logic [CNT_W-1:0] stallcnt
`endif
);

  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t        state_q, state_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] store_q, store_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic              ihit_q, ihit_d;
  logic              dhit_q, dhit_d;
  logic [WORD_W-1:0] iload_q, iload_d;
  logic [WORD_W-1:0] dload_q, dload_d;
  logic              merr_q, merr_d;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;
  logic              req_c;

  // State and output registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      ihit_q  <= 1'b0;
      dhit_q  <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
      merr_q  <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      ihit_q  <= ihit_d;
      dhit_q  <= dhit_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      merr_q  <= merr_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Requester still asking for the transaction in service
  assign req_c = (state_q == DSVC) ? (bus.dREN | bus.dWEN) : bus.iREN;

  // Next state and next registered outputs
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    store_d = store_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    ihit_d  = 1'b0;
    dhit_d  = 1'b0;
    iload_d = iload_q;
    dload_d = dload_q;
    merr_d  = merr_q;
    tcnt_d  = tcnt_q;

    case (state_q)
      IDLE: begin
        ren_d = 1'b0;
        wen_d = 1'b0;
        // The hit cycle itself never arbitrates, which guarantees an idle gap
        // and keeps a still-held request from being served twice.
        if (!ihit_q && !dhit_q) begin
          if (bus.dREN || bus.dWEN) begin
            state_d = DSVC;
            addr_d  = bus.daddr;
            store_d = bus.dstore;
            wen_d   = bus.dWEN;
            ren_d   = ~bus.dWEN;
            tcnt_d  = '0;
          end else if (bus.iREN) begin
            state_d = ISVC;
            addr_d  = bus.iaddr;
            store_d = '0;
            ren_d   = 1'b1;
            tcnt_d  = '0;
          end
        end
      end

      DSVC, ISVC: begin
        if (bus.ramstate == ERROR) begin
          state_d = ERR;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          merr_d  = 1'b1;
        end else if (bus.ramstate == ACCESS) begin
          state_d = IDLE;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          if (state_q == DSVC) begin
            dhit_d  = 1'b1;
            dload_d = bus.ramload;
          end else begin
            ihit_d  = 1'b1;
            iload_d = bus.ramload;
          end
        end else if (!req_c) begin
          state_d = IDLE;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
        end else if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d = ERR;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          merr_d  = 1'b1;
        end else begin
          tcnt_d = TO_W'(tcnt_q + 1'b1);
        end
      end

      ERR: begin
        ren_d  = 1'b0;
        wen_d  = 1'b0;
        merr_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.ramREN   = ren_q;
  assign bus.ramWEN   = wen_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.ihit     = ihit_q;
  assign bus.dhit     = dhit_q;
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
  assign bus.merr     = merr_q;

`ifdef MEMCTL_STATS_EN
  // Saturating hit and stall statistics
  if (1) begin : g_stats
    logic [CNT_W-1:0] icnt_q, dcnt_q, stall_q;

    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        icnt_q  <= '0;
        dcnt_q  <= '0;
        stall_q <= '0;
      end else begin
        if (ihit_d && (icnt_q != '1)) icnt_q <= CNT_W'(icnt_q + 1'b1);
        if (dhit_d && (dcnt_q != '1)) dcnt_q <= CNT_W'(dcnt_q + 1'b1);
        if ((state_q == DSVC) && bus.iREN && (stall_q != '1))
          stall_q <= CNT_W'(stall_q + 1'b1);
      end
    end

    assign icnt     = icnt_q;
    assign dcnt     = dcnt_q;
    assign stallcnt = stall_q;
  end
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  logic CLK;
  logic nRST;

  memory_arbiter_if bus();

`ifdef MEMCTL_STATS_EN
  logic [31:0] icnt, dcnt, stallcnt;
`endif

  memory_arbiter dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .bus      (bus)
`ifdef MEMCTL_STATS_EN
    , .icnt     (icnt)
    , .dcnt     (dcnt)
    , .stallcnt (stallcnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;
  int unsigned n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  int n;

  initial begin
    nRST         = 1'b0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;
    tick();
    tick();

    // Reset state
    check("rst_ramREN", 32'(bus.ramREN), 32'd0);
    check("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    check("rst_ihit",   32'(bus.ihit),   32'd0);
    check("rst_dhit",   32'(bus.dhit),   32'd0);
    check("rst_merr",   32'(bus.merr),   32'd0);
    check("rst_ramaddr", bus.ramaddr,    32'd0);
    nRST = 1'b1;
    tick();

    // 1: instruction read, ACCESS on third service cycle
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h40;
    tick();
    check("t1_ramREN", 32'(bus.ramREN), 32'd1);
    check("t1_ramaddr", bus.ramaddr, 32'h40);
    bus.ramstate = BUSY;
    tick();
    check("t1_hold_ramREN", 32'(bus.ramREN), 32'd1);
    check("t1_no_early_hit", 32'(bus.ihit), 32'd0);
    tick();
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h3C010001;
    tick();
    check("t1_ihit", 32'(bus.ihit), 32'd1);
    check("t1_iload", bus.iload, 32'h3C010001);
    check("t1_strobe_off", 32'(bus.ramREN), 32'd0);
    bus.iREN     = 1'b0;
    bus.ramstate = FREE;
    bus.ramload  = 32'h0;
    tick();
    check("t1_ihit_pulse", 32'(bus.ihit), 32'd0);
    check("t1_iload_hold", bus.iload, 32'h3C010001);

    // 2: simultaneous requests, data wins, instruction stalls then completes
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h44;
    bus.dREN  = 1'b1;
    bus.daddr = 32'h100;
    tick();
    check("t2_d_first_addr", bus.ramaddr, 32'h100);
    check("t2_d_ren", 32'(bus.ramREN), 32'd1);
    bus.ramstate = BUSY;
    tick();
    tick();
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h11112222;
    tick();
    check("t2_dhit", 32'(bus.dhit), 32'd1);
    check("t2_no_ihit", 32'(bus.ihit), 32'd0);
    check("t2_dload", bus.dload, 32'h11112222);
    bus.dREN     = 1'b0;
    bus.ramstate = FREE;
    tick();
    check("t2_gap_idle", 32'(bus.ramREN), 32'd0);
    check("t2_dhit_pulse", 32'(bus.dhit), 32'd0);
    tick();
    check("t2_i_grant", 32'(bus.ramREN), 32'd1);
    check("t2_i_addr", bus.ramaddr, 32'h44);
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h22223333;
    tick();
    check("t2_ihit", 32'(bus.ihit), 32'd1);
    check("t2_iload", bus.iload, 32'h22223333);
    check("t2_dload_hold", bus.dload, 32'h11112222);
`ifdef MEMCTL_STATS_EN
    check("t2_stallcnt", stallcnt, 32'd3);
    check("t2_icnt", icnt, 32'd2);
    check("t2_dcnt", dcnt, 32'd1);
`endif
    bus.iREN     = 1'b0;
    bus.ramstate = FREE;
    tick();

    // 3: data write
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h80;
    bus.dstore = 32'hDEADBEEF;
    tick();
    check("t3_ramWEN", 32'(bus.ramWEN), 32'd1);
    check("t3_ramREN", 32'(bus.ramREN), 32'd0);
    check("t3_ramstore", bus.ramstore, 32'hDEADBEEF);
    check("t3_ramaddr", bus.ramaddr, 32'h80);
    bus.ramstate = BUSY;
    tick();
    check("t3_hold_wen", 32'(bus.ramWEN), 32'd1);
    bus.ramstate = ACCESS;
    tick();
    check("t3_dhit", 32'(bus.dhit), 32'd1);
    check("t3_no_ihit", 32'(bus.ihit), 32'd0);
    check("t3_wen_off", 32'(bus.ramWEN), 32'd0);
    bus.dWEN     = 1'b0;
    bus.ramstate = FREE;
    tick();

    // dREN and dWEN together behave as a write
    bus.dREN   = 1'b1;
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h84;
    bus.dstore = 32'h0BADF00D;
    tick();
    check("both_wen", 32'(bus.ramWEN), 32'd1);
    check("both_ren", 32'(bus.ramREN), 32'd0);
    bus.ramstate = ACCESS;
    tick();
    check("both_dhit", 32'(bus.dhit), 32'd1);
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.ramstate = FREE;
    tick();

    // 5: abort by dropping dREN before ACCESS
    bus.dREN  = 1'b1;
    bus.daddr = 32'h200;
    tick();
    check("t5_grant", 32'(bus.ramREN), 32'd1);
    bus.ramstate = BUSY;
    bus.dREN     = 1'b0;
    tick();
    check("t5_abort_ren", 32'(bus.ramREN), 32'd0);
    check("t5_no_dhit", 32'(bus.dhit), 32'd0);
    bus.ramstate = FREE;
    tick();
    check("t5_idle_no_dhit", 32'(bus.dhit), 32'd0);
    check("t5_idle_ren", 32'(bus.ramREN), 32'd0);

    // 6: reset pulsed mid-ISVC
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h60;
    tick();
    check("t6_grant", 32'(bus.ramREN), 32'd1);
    #2 nRST = 1'b0;
    #1;
    check("t6_rst_ren", 32'(bus.ramREN), 32'd0);
    check("t6_rst_addr", bus.ramaddr, 32'd0);
    check("t6_rst_iload", bus.iload, 32'd0);
    check("t6_rst_ihit", 32'(bus.ihit), 32'd0);
    #2 nRST = 1'b1;
    tick();
    check("t6_regrant", 32'(bus.ramREN), 32'd1);
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h00000055;
    tick();
    check("t6_ihit", 32'(bus.ihit), 32'd1);
    check("t6_iload", bus.iload, 32'h00000055);
    bus.iREN     = 1'b0;
    bus.ramstate = FREE;
    tick();

    // 4: RAM stuck BUSY -> timeout into sticky ERR
    bus.dREN     = 1'b1;
    bus.daddr    = 32'h300;
    bus.ramstate = BUSY;
    n = 0;
    tick();
    while (!bus.merr && n < 40) begin
      n++;
      tick();
    end
    check("t4_timeout_cycles", 32'(n), 32'd32);
    check("t4_merr", 32'(bus.merr), 32'd1);
    check("t4_err_ren", 32'(bus.ramREN), 32'd0);
    bus.dREN     = 1'b0;
    bus.ramstate = FREE;
    bus.iREN     = 1'b1;
    bus.iaddr    = 32'h10;
    tick();
    tick();
    tick();
    check("t4_err_no_ihit", 32'(bus.ihit), 32'd0);
    check("t4_err_no_ren", 32'(bus.ramREN), 32'd0);
    check("t4_merr_sticky", 32'(bus.merr), 32'd1);
    bus.iREN = 1'b0;
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    check("t4_merr_cleared", 32'(bus.merr), 32'd0);
    tick();

    // RAM ERROR status also traps
    bus.dREN  = 1'b1;
    bus.daddr = 32'h304;
    tick();
    bus.ramstate = ERROR;
    tick();
    check("err_merr", 32'(bus.merr), 32'd1);
    check("err_ren_off", 32'(bus.ramREN), 32'd0);
    check("err_no_dhit", 32'(bus.dhit), 32'd0);
    bus.dREN     = 1'b0;
    bus.ramstate = FREE;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
